io_bus_master: RTL and testbench

- Initiator side of the memory-mapped IO bus.
- Converts single CPU data-port load/store requests into AS_L/WE_L bus cycles towards the IO handler.
- Generates byte enables and write-lane replication, then returns aligned, sign/zero-extended read data.
- Sits between the CPU load/store unit and the IO handler; one outstanding transaction at a time.

---
 rtl/io_bus_pkg.sv | 17 +
 rtl/io_lane_align.sv | 58 +++++
 rtl/io_bus_master.sv | 146 ++++++++++++++
 tb/tb_io_bus_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared types and constants for the IO bus master
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [15:0] IO_BASE_HI_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/io_lane_align.sv
// rtl/io_lane_align.sv - byte enables, write lane replication and read extract/extend
import io_bus_pkg::*;

module io_lane_align (
    // write/request side, fed from the live request at accept time
    input  logic [1:0]  addr_w,
    input  logic [1:0]  size_w,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic        misaligned,
    // read side, fed from the registered request fields
    input  logic [1:0]  addr_r,
    input  logic [1:0]  size_r,
    input  logic        unsigned_r,
    input  logic [31:0] rdata_raw,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_sh;

    // Lane enables and replicated store data; replication keeps lane 0 valid for narrow handler registers
    always_comb begin
        be          = 4'b0000;
        wdata_lanes = wdata;
        misaligned  = 1'b0;
        case (size_w)
            SIZE_B: begin
                be          = 4'b0001 << addr_w;
                wdata_lanes = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                be          = 4'b0011 << addr_w;
                wdata_lanes = {2{wdata[15:0]}};
                misaligned  = addr_w[0];
            end
            SIZE_W: begin
                be          = 4'hF;
                misaligned  = (addr_w != 2'b00);
            end
            default: be = 4'b0000;
        endcase
    end

    // Bring the addressed lane down to bit 0, then sign or zero extend
    always_comb begin
        rdata_sh  = rdata_raw >> {addr_r, 3'b000};
        rdata_ext = rdata_raw;
        case (size_r)
            SIZE_B:  rdata_ext = unsigned_r ? {24'h0, rdata_sh[7:0]}
                                            : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            SIZE_H:  rdata_ext = unsigned_r ? {16'h0, rdata_sh[15:0]}
                                            : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            default: rdata_ext = rdata_raw;
        endcase
    end

endmodule

// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - CPU load/store to AS_L/WE_L IO bus initiator (option: IO_POSTED_WRITE_EN)
import io_bus_pkg::*;

module io_bus_master #(
    parameter logic [15:0] IO_BASE_HI  = IO_BASE_HI_DEFAULT,
    parameter int          WAIT_STATES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req_valid,
    output logic        Req_ready,
    input  logic [31:0] Req_addr,
    input  logic        Req_we,
    input  logic [1:0]  Req_size,
    input  logic        Req_unsigned,
    input  logic [31:0] Req_wdata,
    output logic        Rsp_valid,
    output logic [31:0] Rsp_rdata,
    output logic        Rsp_err,
    output logic        AS_L,
    output logic        WE_L,
    output logic        IO_Select,
    output logic [31:0] Address,
    output logic [31:0] IO_data_out,
    input  logic [31:0] IO_data_in,
    output logic [3:0]  byte_enable
);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
`ifdef IO_POSTED_WRITE_EN
    logic        posted_q;
`endif

    logic [3:0]  be_w;
    logic [31:0] wdata_lanes;
    logic [31:0] rdata_ext;
    logic        misaligned;
    logic        req_err;

    io_lane_align u_align (
        .addr_w      (Req_addr[1:0]),
        .size_w      (Req_size),
        .wdata       (Req_wdata),
        .be          (be_w),
        .wdata_lanes (wdata_lanes),
        .misaligned  (misaligned),
        .addr_r      (addr_lo_q),
        .size_r      (size_q),
        .unsigned_r  (uns_q),
        .rdata_raw   (IO_data_in),
        .rdata_ext   (rdata_ext)
    );

    assign req_err   = (Req_addr[31:16] != IO_BASE_HI) || (Req_size == 2'd3) || misaligned;
    assign Req_ready = (state == IDLE);

    // Bus cycle sequencer with registered bus and response outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            addr_lo_q   <= 2'b00;
            size_q      <= 2'b00;
            AS_L        <= 1'b1;
            WE_L        <= 1'b1;
            IO_Select   <= 1'b0;
            Address     <= 32'h0;
            IO_data_out <= 32'h0;
            byte_enable <= 4'h0;
            Rsp_valid   <= 1'b0;
            Rsp_rdata   <= 32'h0;
            Rsp_err     <= 1'b0;
`ifdef IO_POSTED_WRITE_EN
            posted_q    <= 1'b0;
`endif
        end else begin
            Rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req_valid) begin
                        we_q      <= Req_we;
                        uns_q     <= Req_unsigned;
                        addr_lo_q <= Req_addr[1:0];
                        size_q    <= Req_size;
                        if (req_err) begin
                            // no bus cycle: answer straight away
                            state     <= RESPOND;
                            Rsp_valid <= 1'b1;
                            Rsp_err   <= 1'b1;
                            Rsp_rdata <= 32'h0;
                        end else begin
                            state       <= SETUP;
                            IO_Select   <= 1'b1;
                            WE_L        <= ~Req_we;
                            Address     <= Req_addr;
                            byte_enable <= be_w;
                            IO_data_out <= wdata_lanes;
                            Rsp_err     <= 1'b0;
`ifdef IO_POSTED_WRITE_EN
                            posted_q    <= Req_we;
                            if (Req_we) begin
                                Rsp_valid <= 1'b1;
                                Rsp_rdata <= 32'h0;
                            end
`endif
                        end
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    AS_L     <= 1'b0;
                    wait_cnt <= 4'(WAIT_STATES);
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state       <= RESPOND;
                        AS_L        <= 1'b1;
                        WE_L        <= 1'b1;
                        IO_Select   <= 1'b0;
                        byte_enable <= 4'h0;
                        Rsp_rdata   <= we_q ? 32'h0 : rdata_ext;
`ifdef IO_POSTED_WRITE_EN
                        Rsp_valid   <= ~posted_q;
`else
                        Rsp_valid   <= 1'b1;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// tb/tb_io_bus_master.sv - directed self-checking bench for io_bus_master
module tb_io_bus_master;

`ifdef IO_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Req_valid = 1'b0;
    logic        Req_ready;
    logic [31:0] Req_addr = 32'h0;
    logic        Req_we = 1'b0;
    logic [1:0]  Req_size = 2'd0;
    logic        Req_unsigned = 1'b0;
    logic [31:0] Req_wdata = 32'h0;
    logic        Rsp_valid;
    logic [31:0] Rsp_rdata;
    logic        Rsp_err;
    logic        AS_L;
    logic        WE_L;
    logic        IO_Select;
    logic [31:0] Address;
    logic [31:0] IO_data_out;
    logic [31:0] IO_data_in = 32'h0;
    logic [3:0]  byte_enable;

    int checks = 0;
    int errors = 0;

    io_bus_master #(.IO_BASE_HI(16'hFFFF), .WAIT_STATES(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_addr(Req_addr),
        .Req_we(Req_we), .Req_size(Req_size), .Req_unsigned(Req_unsigned),
        .Req_wdata(Req_wdata), .Rsp_valid(Rsp_valid), .Rsp_rdata(Rsp_rdata),
        .Rsp_err(Rsp_err), .AS_L(AS_L), .WE_L(WE_L), .IO_Select(IO_Select),
        .Address(Address), .IO_data_out(IO_data_out), .IO_data_in(IO_data_in),
        .byte_enable(byte_enable)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Issue one request and observe it until the block is idle again; k counts cycles after accept
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wd, input logic [31:0] din,
                           output int rsp_k, output int rsp_cnt, output int as_low,
                           output int we_low, output int sel_cnt, output logic [3:0] be_seen,
                           output logic [31:0] dout_seen, output logic [31:0] rdata,
                           output logic err, output logic setup_ok);
        int wait_n = 0;
        rsp_k = 0; rsp_cnt = 0; as_low = 0; we_low = 0; sel_cnt = 0;
        be_seen = 4'h0; dout_seen = 32'h0; rdata = 32'hDEADBEEF; err = 1'bx; setup_ok = 1'b0;
        while (!Req_ready && wait_n < 20) begin
            step();
            wait_n++;
        end
        IO_data_in = din;
        Req_we = we; Req_addr = addr; Req_size = size; Req_unsigned = uns; Req_wdata = wd;
        Req_valid = 1'b1;
        step();
        Req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) setup_ok = (AS_L === 1'b1) && (IO_Select === 1'b1);
            if (AS_L === 1'b0) begin
                as_low++;
                be_seen = byte_enable;
                dout_seen = IO_data_out;
            end
            if (WE_L === 1'b0) we_low++;
            if (IO_Select === 1'b1) sel_cnt++;
            if (Rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (rsp_k == 0) begin
                    rsp_k = k;
                    rdata = Rsp_rdata;
                    err = Rsp_err;
                end
            end
            if (Req_ready && rsp_k != 0) break;
            step();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(); step();
        checks++;
        if ({AS_L, WE_L, IO_Select, Rsp_valid, Rsp_err, Req_ready} !== 6'b110001) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 110001", {AS_L, WE_L, IO_Select, Rsp_valid, Rsp_err, Req_ready});
        end
        checks++;
        if ({Address, IO_data_out, Rsp_rdata, byte_enable} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data addr=%h dout=%h rdata=%h be=%h want all zero", Address, IO_data_out, Rsp_rdata, byte_enable);
        end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_load_word();
        int rk, rc, al, wl, sc; logic [3:0] be; logic [31:0] dout, rd; logic er, su;
        run_txn(1'b0, 32'hFFFF0000, 2'd2, 1'b0, 32'h0, 32'h000003A5, rk, rc, al, wl, sc, be, dout, rd, er, su);
        checks++; if (al !== 3) begin errors++; $display("FAIL lw_as_low got %0d want 3", al); end
        checks++; if (be !== 4'hF) begin errors++; $display("FAIL lw_be got %h want f", be); end
        checks++; if (rk !== 5) begin errors++; $display("FAIL lw_latency got %0d want 5", rk); end
        checks++; if (rd !== 32'h000003A5 || er !== 1'b0) begin errors++; $display("FAIL lw_rdata got %h err %b want 000003a5 err 0", rd, er); end
        checks++; if (su !== 1'b1 || wl !== 0 || rc !== 1) begin errors++; $display("FAIL lw_setup got setup %b we_low %0d rsp %0d want 1 0 1", su, wl, rc); end
    endtask

    task automatic test_store_byte();
        int rk, rc, al, wl, sc; logic [3:0] be; logic [31:0] dout, rd; logic er, su;
        run_txn(1'b1, 32'hFFFF0004, 2'd0, 1'b0, 32'h1234567E, 32'h0, rk, rc, al, wl, sc, be, dout, rd, er, su);
        checks++; if (dout !== 32'h7E7E7E7E) begin errors++; $display("FAIL sb_dout got %h want 7e7e7e7e", dout); end
        checks++; if (be !== 4'b0001) begin errors++; $display("FAIL sb_be got %b want 0001", be); end
        checks++; if (wl !== 4) begin errors++; $display("FAIL sb_we_low got %0d want 4", wl); end
        checks++; if (rk !== (POSTED ? 1 : 5) || rc !== 1) begin errors++; $display("FAIL sb_latency got %0d (%0d rsp) want %0d (1 rsp)", rk, rc, POSTED ? 1 : 5); end
        checks++; if (rd !== 32'h0 || er !== 1'b0 || al !== 3) begin errors++; $display("FAIL sb_rsp got rdata %h err %b as_low %0d want 0 0 3", rd, er, al); end
    endtask

    task automatic test_narrow_loads();
        int rk, rc, al, wl, sc; logic [3:0] be; logic [31:0] dout, rd; logic er, su;
        run_txn(1'b0, 32'hFFFF0003, 2'd0, 1'b0, 32'h0, 32'h80000000, rk, rc, al, wl, sc, be, dout, rd, er, su);
        checks++; if (rd !== 32'hFFFFFF80 || be !== 4'b1000) begin errors++; $display("FAIL lb_sext got %h be %b want ffffff80 1000", rd, be); end
        run_txn(1'b0, 32'hFFFF0003, 2'd0, 1'b1, 32'h0, 32'h80000000, rk, rc, al, wl, sc, be, dout, rd, er, su);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got %h want 00000080", rd); end
        run_txn(1'b0, 32'hFFFF0002, 2'd1, 1'b0, 32'h0, 32'h80011234, rk, rc, al, wl, sc, be, dout, rd, er, su);
        checks++; if (rd !== 32'hFFFF8001 || be !== 4'b1100) begin errors++; $display("FAIL lh_sext got %h be %b want ffff8001 1100", rd, be); end
        run_txn(1'b1, 32'hFFFF0002, 2'd1, 1'b0, 32'hABCD1234, 32'h0, rk, rc, al, wl, sc, be, dout, rd, er, su);
        checks++; if (dout !== 32'h12341234 || be !== 4'b1100) begin errors++; $display("FAIL sh_lanes got %h be %b want 12341234 1100", dout, be); end
    endtask

    task automatic test_errors();
        int rk, rc, al, wl, sc; logic [3:0] be; logic [31:0] dout, rd; logic er, su;
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs[0] = 32'hFFFF0001; sizes[0] = 2'd1;
        addrs[1] = 32'h00001000; sizes[1] = 2'd2;
        addrs[2] = 32'hFFFF0000; sizes[2] = 2'd3;
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b0, addrs[i], sizes[i], 1'b0, 32'h0, 32'hFFFFFFFF, rk, rc, al, wl, sc, be, dout, rd, er, su);
            checks++;
            if (rk !== 1 || er !== 1'b1 || rd !== 32'h0) begin
                errors++; $display("FAIL err_rsp[%0d] got k=%0d err=%b rdata=%h want k=1 err=1 rdata=0", i, rk, er, rd);
            end
            checks++;
            if (al !== 0 || sc !== 0) begin
                errors++; $display("FAIL err_nobus[%0d] got as_low=%0d sel=%0d want 0 0", i, al, sc);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int rsp_seen = 0;
        IO_data_in = 32'h11111111;
        Req_we = 1'b0; Req_addr = 32'hFFFF0000; Req_size = 2'd2; Req_unsigned = 1'b0;
        Req_valid = 1'b1;
        step();
        Req_valid = 1'b0;
        step(); step();   // now in the second ACCESS cycle
        checks++;
        if (AS_L !== 1'b0) begin errors++; $display("FAIL rst_pre got AS_L %b want 0", AS_L); end
        Reset = 1'b1;
        step();
        checks++;
        if ({AS_L, IO_Select, Req_ready, Rsp_valid} !== 4'b1010) begin
            errors++; $display("FAIL rst_abort got %b want 1010", {AS_L, IO_Select, Req_ready, Rsp_valid});
        end
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (Rsp_valid === 1'b1) rsp_seen++;
            step();
        end
        checks++;
        if (rsp_seen !== 0) begin errors++; $display("FAIL rst_no_rsp got %0d responses want 0", rsp_seen); end
    endtask

    task automatic test_back_to_back();
        int st_k = 0, lw_acc_k = 0, lw_k = 0, rsp_n = 0;
        logic [31:0] lw_rd = 32'h0;
        bit lw_pend;
        IO_data_in = 32'h00005A5A;
        Req_we = 1'b1; Req_addr = 32'hFFFF0008; Req_size = 2'd2; Req_unsigned = 1'b0; Req_wdata = 32'hCAFEF00D;
        Req_valid = 1'b1;
        step();
        // the load is presented immediately and held until taken
        Req_we = 1'b0; Req_addr = 32'hFFFF0000; Req_wdata = 32'h0;
        lw_pend = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (Rsp_valid === 1'b1) begin
                rsp_n++;
                if (st_k == 0) st_k = k;
                else if (lw_k == 0) begin lw_k = k; lw_rd = Rsp_rdata; end
            end
            if (lw_pend && Req_ready === 1'b1) lw_acc_k = k;
            step();
            if (lw_acc_k != 0 && lw_pend) begin
                lw_pend = 1'b0;
                Req_valid = 1'b0;
            end
        end
        Req_valid = 1'b0;
        checks++;
        if (st_k !== (POSTED ? 1 : 5)) begin errors++; $display("FAIL b2b_store_rsp got %0d want %0d", st_k, POSTED ? 1 : 5); end
        checks++;
        if (lw_acc_k !== 6) begin errors++; $display("FAIL b2b_lw_accept got %0d want 6", lw_acc_k); end
        checks++;
        if (lw_k !== 11 || lw_rd !== 32'h00005A5A || rsp_n !== 2) begin
            errors++; $display("FAIL b2b_lw_rsp got k=%0d rdata=%h n=%0d want 11 00005a5a 2", lw_k, lw_rd, rsp_n);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_narrow_loads();
        test_errors();
        test_reset_mid_access();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
